// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Types:     word_t (datapath word), regidx_t (register index).
// Constants: architectural register indices and the $sp reset value.
// RegDST:    destination-select encodings shared by control, the mux and benches,
//            plus a helper that models the mux itself.
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regidx_t;

    localparam regidx_t REG_ZERO     = 5'd0;
    localparam regidx_t REG_SP       = 5'd29;
    localparam regidx_t REG_RA       = 5'd31;
    localparam word_t   SP_RESET_VAL = 32'd227;

    typedef enum logic [1:0] {
        RegDstRs = 2'b00,
        RegDstRa = 2'b01,
        RegDstSp = 2'b10,
        RegDstRt = 2'b11
    } reg_dst_e;

    // Behaviour of the RegDST mux that feeds write_reg.
    function automatic regidx_t reg_dst_index(reg_dst_e sel, regidx_t rs, regidx_t rt);
        regidx_t idx;
        unique case (sel)
            RegDstRs: idx = rs;
            RegDstRa: idx = REG_RA;
            RegDstSp: idx = REG_SP;
            RegDstRt: idx = rt;
            default:  idx = rs;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/banco_reg_if.sv
// Register-file access bundle.
// master (datapath side): drives reg_write, write_reg, write_data, read_reg1, read_reg2;
//                         receives read_data1, read_data2.
// slave  (register file): the mirror image.
interface banco_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();

    logic              reg_write;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output reg_write,
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  reg_write,
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        output read_data1,
        output read_data2
    );

endinterface

// File: rtl/banco_reg.sv
// 32 x 32-bit general-purpose register file for the multicycle MIPS datapath.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all entries except $sp, which loads SP_RESET
//   bus   - banco_reg_if.slave: one synchronous write port, two combinational read ports
// Entry 0 has no storage and always reads as zero. There is no write-through bypass:
// a read of the entry being written shows the old value until the clock edge.
module banco_reg
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_VAL),
    parameter int unsigned       SP_INDEX = int'(REG_SP),
    parameter int unsigned       RA_INDEX = int'(REG_RA)
) (
    input  logic        clk,
    input  logic        reset,
    banco_reg_if.slave  bus
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    // Reject parameter sets that would place $sp/$ra on the zero register or outside the file.
    if (SP_INDEX == 0 || SP_INDEX >= NumRegs || RA_INDEX == 0 || RA_INDEX >= NumRegs)
    begin : gen_bad_index
        $error("banco_reg: SP_INDEX/RA_INDEX out of range");
    end

    logic [DATA_W-1:0] regs_q [1:NumRegs-1];
    logic [DATA_W-1:0] regs_d [1:NumRegs-1];
    logic              wr_en;

    // Index 0 writes are dropped here; write_reg/write_data are don't-care when reg_write=0.
    assign wr_en = bus.reg_write && (bus.write_reg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.write_reg] = bus.write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < NumRegs; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.read_data1 = (bus.read_reg1 == '0) ? '0 : regs_q[bus.read_reg1];
    assign bus.read_data2 = (bus.read_reg2 == '0) ? '0 : regs_q[bus.read_reg2];

endmodule

// File: tb/tb_banco_reg.sv
// Directed self-checking bench for banco_reg.
module tb_banco_reg;
    import mips_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    banco_reg_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    banco_reg #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .SP_RESET(32'd227),
        .SP_INDEX(29),
        .RA_INDEX(31)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write at the falling edge, let the rising edge commit it, then idle the port.
    task automatic do_write(input regidx_t idx, input word_t data);
        @(negedge clk);
        bus.reg_write  = 1'b1;
        bus.write_reg  = idx;
        bus.write_data = data;
        @(posedge clk);
        #1;
        bus.reg_write  = 1'b0;
        bus.write_reg  = 'x;
        bus.write_data = 'x;
    endtask

    task automatic test_reset;
        word_t exp1, exp2;
        @(negedge clk);
        #2;
        reset = 1'b1;   // no clock edge between here and the first check
        for (int i = 0; i < 16; i++) begin
            bus.read_reg1 = regidx_t'(i);
            bus.read_reg2 = regidx_t'(i + 16);
            #1;
            exp1 = 32'd0;
            exp2 = (i + 16 == 29) ? 32'd227 : 32'd0;
            n_checks++;
            if (bus.read_data1 !== exp1) begin
                n_fail++;
                $display("FAIL reset_r%0d: got %h expected %h", i, bus.read_data1, exp1);
            end
            n_checks++;
            if (bus.read_data2 !== exp2) begin
                n_fail++;
                $display("FAIL reset_r%0d: got %h expected %h", i + 16, bus.read_data2, exp2);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_write;
        do_write(5'd8, 32'hDEADBEEF);
        bus.read_reg1 = 5'd8;
        bus.read_reg2 = 5'd9;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_write_r8: got %h expected %h", bus.read_data1, 32'hDEADBEEF);
        end
        n_checks++;
        if (bus.read_data2 !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_write_r9: got %h expected %h", bus.read_data2, 32'h0);
        end
    endtask

    task automatic test_zero_reg;
        do_write(REG_ZERO, 32'hFFFFFFFF);
        bus.read_reg1 = 5'd0;
        bus.read_reg2 = 5'd8;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg: got %h expected %h", bus.read_data1, 32'h0);
        end
        n_checks++;
        if (bus.read_data2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL zero_reg_r8_kept: got %h expected %h", bus.read_data2, 32'hDEADBEEF);
        end
    endtask

    task automatic test_regdst;
        do_write(reg_dst_index(RegDstRa, 5'd4, 5'd6), 32'h00000044);
        do_write(reg_dst_index(RegDstSp, 5'd4, 5'd6), 32'd223);
        bus.read_reg1 = 5'd31;
        bus.read_reg2 = 5'd29;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h44) begin
            n_fail++;
            $display("FAIL regdst_ra: got %h expected %h", bus.read_data1, 32'h44);
        end
        n_checks++;
        if (bus.read_data2 !== 32'd223) begin
            n_fail++;
            $display("FAIL regdst_sp: got %h expected %h", bus.read_data2, 32'd223);
        end
        // Reset restores $sp and clears $ra.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL regdst_reset_ra: got %h expected %h", bus.read_data1, 32'h0);
        end
        n_checks++;
        if (bus.read_data2 !== 32'd227) begin
            n_fail++;
            $display("FAIL regdst_reset_sp: got %h expected %h", bus.read_data2, 32'd227);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_during_write;
        do_write(5'd5, 32'h11);
        @(negedge clk);
        bus.read_reg1  = 5'd5;
        bus.read_reg2  = 5'd5;
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd5;
        bus.write_data = 32'h22;
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h11 || bus.read_data2 !== 32'h11) begin
            n_fail++;
            $display("FAIL rdw_before: got %h/%h expected %h", bus.read_data1, bus.read_data2,
                     32'h11);
        end
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        n_checks++;
        if (bus.read_data1 !== 32'h22 || bus.read_data2 !== 32'h22) begin
            n_fail++;
            $display("FAIL rdw_after: got %h/%h expected %h", bus.read_data1, bus.read_data2,
                     32'h22);
        end
    endtask

    task automatic test_write_gating;
        do_write(5'd3, 32'h77);
        @(negedge clk);
        bus.reg_write  = 1'b0;
        bus.write_reg  = 5'd3;
        bus.write_data = 32'hAA;
        bus.read_reg1  = 5'd3;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h77) begin
            n_fail++;
            $display("FAIL write_gating: got %h expected %h", bus.read_data1, 32'h77);
        end
    endtask

    task automatic test_reset_release;
        @(negedge clk);
        reset          = 1'b1;
        bus.reg_write  = 1'b1;
        bus.write_reg  = 5'd3;
        bus.write_data = 32'h55;
        bus.read_reg1  = 5'd3;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL release_during_reset: got %h expected %h", bus.read_data1, 32'h0);
        end
        #2;
        reset = 1'b0;   // released mid-cycle with reg_write still high
        #1;
        n_checks++;
        if (bus.read_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL release_before_edge: got %h expected %h", bus.read_data1, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        n_checks++;
        if (bus.read_data1 !== 32'h55) begin
            n_fail++;
            $display("FAIL release_after_edge: got %h expected %h", bus.read_data1, 32'h55);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.reg_write  = 1'b0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.read_reg1  = '0;
        bus.read_reg2  = '0;

        test_reset();
        test_basic_write();
        test_zero_reg();
        test_regdst();
        test_read_during_write();
        test_write_gating();
        test_reset_release();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
